// File: rtl/act_pingpong_buf.sv
// Double-buffered activation buffer: packs an AXI-stream into wide words, fills two banks alternately,
// and offers each full bank to the PE with a vld/ack handshake. Optional TLAST framing: ACT_TLAST_EN.
module act_pingpong_buf #(
    parameter int IN_W   = 8,
    parameter int PACK   = 8,
    parameter int DEPTH  = 544,
    parameter int AWIDTH = 10
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [IN_W-1:0]        ActDMA_V_TDATA,
    input  logic                   ActDMA_V_TVALID,
    output logic                   ActDMA_V_TREADY,
    output logic                   SyncSig_V,
    output logic                   SyncSig_V_ap_vld,
    input  logic                   SyncSig_V_ap_ack,
    input  logic                   Rel_V,
    input  logic [AWIDTH-1:0]      ActBuf_Data_address0,
    input  logic                   ActBuf_Data_ce0,
    output logic [IN_W*PACK-1:0]   ActBuf_Data_q0
`ifdef ACT_TLAST_EN
    ,
    input  logic                   ActDMA_V_TLAST,
    output logic [AWIDTH:0]        FrameLen_V
`endif
);
    localparam int DW  = IN_W * PACK;
    localparam int BCW = (PACK > 1) ? $clog2(PACK) : 1;
    localparam logic [BCW-1:0]    LAST_BEAT = BCW'(PACK - 1);
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);
    localparam logic [AWIDTH:0]   DEPTH_W   = (AWIDTH + 1)'(DEPTH);

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    logic [BCW-1:0]    r_bcnt;
    logic [DW-1:0]     r_pack;
    logic [DW-1:0]     r_wr_data;
    logic              r_wr_pend;
    logic              r_wr_close;
    logic [AWIDTH-1:0] r_wr_addr;
    logic              r_fill;
    logic [1:0]        r_full;
    logic              r_held;
    logic              r_rd_bank;
    logic              r_ptr;
    logic              r_tready;
    state_t            r_state;

    logic [DW-1:0]     w_word;
    logic [AWIDTH-1:0] w_word_addr;
    logic [1:0]        w_full_nxt;
    logic              w_fill_nxt;
    logic              w_hs, w_tlast, w_word_done, w_close_hs, w_rel, w_take;
    state_t            w_state_nxt;

    logic [DW-1:0]     r_mem0 [DEPTH];
    logic [DW-1:0]     r_mem1 [DEPTH];

`ifdef ACT_TLAST_EN
    logic [AWIDTH:0]   r_flen [2];
    assign w_tlast     = ActDMA_V_TLAST;
    assign FrameLen_V  = r_flen[r_ptr];
`else
    assign w_tlast     = 1'b0;
`endif

    assign ActDMA_V_TREADY = r_tready;
    assign w_hs        = ActDMA_V_TVALID && r_tready;
    assign w_word_done = w_hs && ((r_bcnt == LAST_BEAT) || w_tlast);
    // A write still in flight this cycle can never be a closing one, so +1 cannot wrap here.
    assign w_word_addr = r_wr_pend ? r_wr_addr + 1'b1 : r_wr_addr;
    assign w_close_hs  = w_word_done && ((w_word_addr == LAST_ADDR) || w_tlast);
    assign w_rel       = Rel_V && r_held;
    assign w_take      = (r_state == S_OFFER) && SyncSig_V_ap_ack;

    always_comb begin
        w_word = r_pack;
        w_word[int'(r_bcnt)*IN_W +: IN_W] = ActDMA_V_TDATA;
    end

    always_comb begin
        w_full_nxt = r_full;
        w_fill_nxt = r_fill;
        if (w_rel)
            w_full_nxt[r_rd_bank] = 1'b0;
        if (r_wr_pend && r_wr_close) begin
            w_full_nxt[r_fill] = 1'b1;
            w_fill_nxt         = ~r_fill;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_bcnt     <= '0;
            r_pack     <= '0;
            r_wr_pend  <= 1'b0;
            r_wr_close <= 1'b0;
            r_wr_data  <= '0;
        end else begin
            r_wr_pend  <= w_word_done;
            r_wr_close <= w_close_hs;
            if (w_word_done)
                r_wr_data <= w_word;
            if (w_hs) begin
                if (w_word_done) begin
                    r_bcnt <= '0;
                    r_pack <= '0;
                end else begin
                    r_bcnt <= r_bcnt + 1'b1;
                    r_pack <= w_word;
                end
            end
        end
    end

    // TREADY drops during the write of a bank's last word so no beat slips into a still-full bank.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_wr_addr <= '0;
            r_fill    <= 1'b0;
            r_full    <= 2'b00;
            r_tready  <= 1'b0;
        end else begin
            if (r_wr_pend)
                r_wr_addr <= r_wr_close ? '0 : r_wr_addr + 1'b1;
            r_fill   <= w_fill_nxt;
            r_full   <= w_full_nxt;
            r_tready <= !w_full_nxt[w_fill_nxt] && !w_close_hs;
        end
    end

`ifdef ACT_TLAST_EN
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_flen[0] <= '0;
            r_flen[1] <= '0;
        end else if (r_wr_pend && r_wr_close) begin
            r_flen[r_fill] <= (AWIDTH + 1)'(r_wr_addr) + 1'b1;
        end
    end
`endif

    always_ff @(posedge ap_clk) begin
        if (r_wr_pend) begin
            if (r_fill)
                r_mem1[r_wr_addr] <= r_wr_data;
            else
                r_mem0[r_wr_addr] <= r_wr_data;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ActBuf_Data_q0 <= '0;
        end else if (ActBuf_Data_ce0) begin
            if (r_held && ({1'b0, ActBuf_Data_address0} < DEPTH_W))
                ActBuf_Data_q0 <= r_rd_bank ? r_mem1[ActBuf_Data_address0]
                                            : r_mem0[ActBuf_Data_address0];
            else
                ActBuf_Data_q0 <= '0;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        SyncSig_V_ap_vld = 1'b0;
        SyncSig_V        = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_ptr] && !r_held)
                    w_state_nxt = S_OFFER;
            end
            S_OFFER: begin
                SyncSig_V_ap_vld = 1'b1;
                if (SyncSig_V_ap_ack)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Release of the old bank is applied before a same-cycle take of the new one.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_held    <= 1'b0;
            r_rd_bank <= 1'b0;
            r_ptr     <= 1'b0;
        end else begin
            if (w_rel)
                r_held <= 1'b0;
            if (w_take) begin
                r_held    <= 1'b1;
                r_rd_bank <= r_ptr;
                r_ptr     <= ~r_ptr;
            end
        end
    end

endmodule

// File: tb/tb_act_pingpong_buf.sv
// Bench for act_pingpong_buf (PACK=8, DEPTH=4): random streams checked against a bank/word-level model.
module tb_act_pingpong_buf;
    localparam int IN_W = 8, PACK = 8, DEPTH = 4, AWIDTH = 3, DW = 64;

    logic              ap_clk, ap_rst_n;
    logic [IN_W-1:0]   tdata;
    logic              tvalid, tready, tlast;
    logic              sync, vld, ack, rel;
    logic [AWIDTH-1:0] addr;
    logic              ce;
    logic [DW-1:0]     q0;
`ifdef ACT_TLAST_EN
    logic [AWIDTH:0]   flen;
`endif

    act_pingpong_buf #(.IN_W(IN_W), .PACK(PACK), .DEPTH(DEPTH), .AWIDTH(AWIDTH)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .ActDMA_V_TDATA(tdata), .ActDMA_V_TVALID(tvalid), .ActDMA_V_TREADY(tready),
        .SyncSig_V(sync), .SyncSig_V_ap_vld(vld), .SyncSig_V_ap_ack(ack),
        .Rel_V(rel), .ActBuf_Data_address0(addr), .ActBuf_Data_ce0(ce), .ActBuf_Data_q0(q0)
`ifdef ACT_TLAST_EN
        , .ActDMA_V_TLAST(tlast), .FrameLen_V(flen)
`endif
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: bank contents as arrays, bookkeeping in plain integers.
    logic [63:0] m_bank [2][DEPTH];
    logic [63:0] m_word;
    int m_bcnt, m_waddr, m_fill, m_rd, m_ptr;
    bit m_full [2];
    bit m_held;
    int m_flen [2];

    task automatic m_reset();
        m_word = 0; m_bcnt = 0; m_waddr = 0; m_fill = 0; m_rd = 0; m_ptr = 0;
        m_full[0] = 0; m_full[1] = 0; m_held = 0; m_flen[0] = 0; m_flen[1] = 0;
    endtask

    task automatic m_beat(input logic [7:0] d, input bit last);
        m_word[m_bcnt*8 +: 8] = d;
        m_bcnt++;
        if (m_bcnt == PACK || last) begin
            m_bank[m_fill][m_waddr] = m_word;
            m_word = 0;
            m_bcnt = 0;
            m_waddr++;
            if (m_waddr == DEPTH || last) begin
                m_full[m_fill] = 1;
                m_flen[m_fill] = m_waddr;
                m_waddr = 0;
                m_fill ^= 1;
            end
        end
    endtask

    function automatic logic [63:0] m_rdval(input int a);
        if (!m_held || a >= DEPTH) return 64'd0;
        return m_bank[m_rd][a];
    endfunction

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic send_beat(input logic [7:0] d, input bit last);
        int n;
        n = 0;
        tdata = d; tlast = last; tvalid = 1'b1;
        while (!tready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            chk("tready_timeout", 64'(tready), 64'd1);
            tvalid = 1'b0;
            return;
        end
        tick();
        tvalid = 1'b0; tlast = 1'b0;
        m_beat(d, last);
    endtask

    task automatic send_rand(input int nbeats, input int maxgap);
        for (int i = 0; i < nbeats; i++) begin
            send_beat(8'($urandom), 1'b0);
            repeat ($urandom_range(0, maxgap)) tick();
        end
    endtask

    task automatic do_ack();
        ack = 1'b1; tick(); ack = 1'b0;
        m_held = 1; m_rd = m_ptr; m_ptr ^= 1;
    endtask

    task automatic do_rel();
        rel = 1'b1; tick(); rel = 1'b0;
        if (m_held) begin
            m_full[m_rd] = 0;
            m_held = 0;
        end
    endtask

    task automatic rd(input int a);
        addr = AWIDTH'(a); ce = 1'b1; tick(); ce = 1'b0;
        chk("rd", q0, m_rdval(a));
    endtask

    task automatic wait_vld(input string tag);
        int n;
        n = 0;
        while (!vld && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 64'(vld), 64'd1);
    endtask

    task automatic apply_reset();
        ap_rst_n = 1'b0; tvalid = 1'b0; ack = 1'b0; rel = 1'b0; ce = 1'b0;
        tick(); tick();
        ap_rst_n = 1'b1;
        m_reset();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ap_rst_n = 1'b0; tdata = '0; tvalid = 1'b0; tlast = 1'b0;
        ack = 1'b0; rel = 1'b0; addr = '0; ce = 1'b0;
        m_reset();
        tick(); tick();
        chk("rst_tready", 64'(tready), 64'd0);
        chk("rst_vld", 64'(vld), 64'd0);
        chk("rst_sync", 64'(sync), 64'd0);
        chk("rst_q0", q0, 64'd0);
        ap_rst_n = 1'b1;
        tick();
        chk("tready_rise", 64'(tready), 64'd1);

        // Sequential bytes into bank 0; offer timing and little-endian packing.
        for (int i = 0; i < 32; i++) send_beat(8'(i + 1), 1'b0);
        chk("vld_h0", 64'(vld), 64'd0);
        tick();
        chk("vld_h1", 64'(vld), 64'd0);
        tick();
        chk("vld_h2", 64'(vld), 64'd1);
        chk("sync_b0", 64'(sync), 64'd0);
        rd(0);
        chk("rd_unheld", q0, 64'd0);
        do_ack();
        chk("vld_drop", 64'(vld), 64'd0);
        rd(0);
        chk("word0", q0, 64'h0807060504030201);
        addr = 3'd2; tick();
        chk("q0_hold", q0, 64'h0807060504030201);
        for (int a = 1; a < 8; a++) rd(a);
        do_rel();

        // Two full banks, no ack: backpressure, stable offer, ignored release.
        apply_reset();
        send_rand(64, 0);
        tick(); tick();
        chk("tready_full", 64'(tready), 64'd0);
        chk("vld_full", 64'(vld), 64'd1);
        for (int i = 0; i < 20; i++) begin
            chk("vld_stable", 64'(vld), 64'd1);
            chk("sync_stable", 64'(sync), 64'd0);
            tick();
        end
        do_rel();
        chk("rel_unheld_tready", 64'(tready), 64'd0);
        chk("rel_unheld_vld", 64'(vld), 64'd1);
        do_ack();
        chk("vld_after_ack", 64'(vld), 64'd0);
        chk("tready_held", 64'(tready), 64'd0);
        for (int a = 0; a < 8; a++) rd(a);
        do_rel();
        chk("tready_after_rel", 64'(tready), 64'd1);
        wait_vld("vld_b1");
        chk("sync_b1", 64'(sync), 64'd1);
        do_ack();
        for (int a = 0; a < 4; a++) rd(a);
        do_rel();
        ack = 1'b1; tick(); ack = 1'b0;
        chk("ack_idle_vld", 64'(vld), 64'd0);
        chk("ack_idle_tready", 64'(tready), 64'd1);
        send_rand(32, 1);
        wait_vld("vld_after_spurious_ack");
        chk("sync_order", 64'(sync), 64'(m_ptr));
        do_ack();
        for (int a = 0; a < 4; a++) rd(a);
        do_rel();

        // Randomised traffic: gaps, ack delays, random reads.
        for (int k = 0; k < 6; k++) begin
            send_rand(32, 2);
            wait_vld("vld_rand");
            chk("sync_rand", 64'(sync), 64'(m_ptr));
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("vld_wait", 64'(vld), 64'd1);
            end
            do_ack();
            chk("tready_rand", 64'(tready), 64'(!m_full[m_fill]));
            for (int r = 0; r < 6; r++) rd(int'($urandom_range(0, 7)));
            do_rel();
        end

        // Reset in the middle of a bank.
        for (int i = 0; i < 13; i++) send_beat(8'($urandom), 1'b0);
        ap_rst_n = 1'b0;
        tick();
        chk("midrst_tready", 64'(tready), 64'd0);
        chk("midrst_vld", 64'(vld), 64'd0);
        ap_rst_n = 1'b1;
        m_reset();
        tick();
        for (int i = 0; i < 32; i++) send_beat(8'(8'h40 + i), 1'b0);
        wait_vld("vld_midrst");
        chk("sync_midrst", 64'(sync), 64'd0);
        do_ack();
        rd(0);
        chk("word0_midrst", q0, 64'h4746454443424140);
        do_rel();

`ifdef ACT_TLAST_EN
        // Early close with a padded partial word.
        apply_reset();
        for (int i = 0; i < 11; i++) send_beat(8'(8'hA1 + i), i == 10);
        tick();
        chk("tl_vld_h1", 64'(vld), 64'd0);
        tick();
        chk("tl_vld_h2", 64'(vld), 64'd1);
        chk("tl_sync", 64'(sync), 64'd0);
        chk("tl_flen", 64'(flen), 64'(m_flen[0]));
        chk("tl_flen2", 64'(flen), 64'd2);
        do_ack();
        rd(1);
        chk("tl_word1", q0, 64'h0000000000ABAAA9);
        do_rel();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
